lsu_ctrl: RTL and testbench

Load/store sequencer placed behind the AGU issue queue. It accepts one issued AGU operation (computed address, store data, destination tag, funct3, load/store flag) and drives a single-outstanding request/acknowledge data-memory port. For loads it performs lane extraction and sign or zero extension, then publishes the result to the CDB arbiter through a request/grant handshake. It pulses ex_done so the queue retires the entry.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_align.sv | 77 +++++++
 rtl/lsu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic LS_STORE = 1'b1;
    localparam logic LS_LOAD  = 1'b0;

    localparam int BE_W = 4;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port and CDB request port of the load/store sequencer.
interface lsu_ctrl_if
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) ();
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic              cdb_req;
    logic [TAG_W-1:0]  cdb_req_tag;
    logic [XLEN-1:0]   cdb_req_data;
    logic              cdb_grant;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output cdb_req, cdb_req_tag, cdb_req_data,
        input  cdb_grant
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  cdb_req, cdb_req_tag, cdb_req_data,
        output cdb_grant
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check, store lane replication,
// byte enables, and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    input  logic             ls,
    input  logic [XLEN-1:0]  sdata,
    output logic             legal,
    output logic [XLEN-1:0]  wdata,
    output logic [BE_W-1:0]  be,
    input  logic [1:0]       ld_addr_lo,
    input  logic [2:0]       ld_funct3,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  ld_result
);

    logic [XLEN-1:0] shifted_s;

    // Legality of the width code for the access kind, plus natural alignment
    always_comb begin
        legal = 1'b0;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = (addr_lo[0] == 1'b0);
            F3_W:    legal = (addr_lo == 2'b00);
            F3_BU:   legal = (ls == LS_LOAD);
            F3_HU:   legal = (ls == LS_LOAD) && (addr_lo[0] == 1'b0);
            default: legal = 1'b0;
        endcase
    end

    // Byte enables follow the access width; loads use the same lanes
    always_comb begin
        be = {BE_W{1'b0}};
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << addr_lo;
            F3_H, F3_HU: be = 4'b0011 << addr_lo;
            F3_W:        be = 4'b1111;
            default:     be = {BE_W{1'b0}};
        endcase
    end

    // Store data is replicated across lanes so memory can pick any enabled byte
    always_comb begin
        wdata = {XLEN{1'b0}};
        if (ls == LS_STORE) begin
            case (funct3)
                F3_B:    wdata = {(XLEN/8){sdata[7:0]}};
                F3_H:    wdata = {(XLEN/16){sdata[15:0]}};
                F3_W:    wdata = sdata;
                default: wdata = {XLEN{1'b0}};
            endcase
        end else begin
            wdata = {XLEN{1'b0}};
        end
    end

    assign shifted_s = rdata >> {ld_addr_lo, 3'b000};

    // Extend the addressed lane to full width
    always_comb begin
        ld_result = {XLEN{1'b0}};
        case (ld_funct3)
            F3_B:    ld_result = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   ld_result = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
            F3_H:    ld_result = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   ld_result = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            F3_W:    ld_result = shifted_s;
            default: ld_result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one AGU op at a time through memory and, for loads, the CDB.
// Every output is a register loaded with its next-cycle value.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [XLEN-1:0]  ex_address,
    input  logic [XLEN-1:0]  ex_data,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic             rd_tag_valid,
    input  logic [2:0]       funct3,
    input  logic             agu_ls,
    output logic             ex_done,
    output logic             misalign_err,
    lsu_ctrl_if.master       bus
);

    lsu_state_e        state_r, state_s;
    logic [1:0]        addr_lo_r, addr_lo_s;
    logic [2:0]        funct3_r, funct3_s;
    logic              ls_r, ls_s;
    logic [TAG_W-1:0]  tag_r, tag_s;
    logic              tag_valid_r, tag_valid_s;

    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [XLEN-1:0]   mem_addr_r, mem_addr_s;
    logic [XLEN-1:0]   mem_wdata_r, mem_wdata_s;
    logic [BE_W-1:0]   mem_be_r, mem_be_s;
    logic              cdb_req_r, cdb_req_s;
    logic [TAG_W-1:0]  cdb_tag_r, cdb_tag_s;
    logic [XLEN-1:0]   cdb_data_r, cdb_data_s;
    logic              ex_done_r, ex_done_s;
    logic              misalign_r, misalign_s;

    logic              legal_s;
    logic [XLEN-1:0]   lane_wdata_s;
    logic [BE_W-1:0]   lane_be_s;
    logic [XLEN-1:0]   ld_result_s;

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo    (ex_address[1:0]),
        .funct3     (funct3),
        .ls         (agu_ls),
        .sdata      (ex_data),
        .legal      (legal_s),
        .wdata      (lane_wdata_s),
        .be         (lane_be_s),
        .ld_addr_lo (addr_lo_r),
        .ld_funct3  (funct3_r),
        .rdata      (bus.mem_rdata),
        .ld_result  (ld_result_s)
    );

    // Next state and next registered outputs
    always_comb begin
        state_s     = state_r;
        addr_lo_s   = addr_lo_r;
        funct3_s    = funct3_r;
        ls_s        = ls_r;
        tag_s       = tag_r;
        tag_valid_s = tag_valid_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_be_s    = mem_be_r;
        cdb_req_s   = cdb_req_r;
        cdb_tag_s   = cdb_tag_r;
        cdb_data_s  = cdb_data_r;
        ex_done_s   = 1'b0;
        misalign_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (issue_valid) begin
                    addr_lo_s   = ex_address[1:0];
                    funct3_s    = funct3;
                    ls_s        = agu_ls;
                    tag_s       = rd_tag;
                    tag_valid_s = rd_tag_valid;
                    if (legal_s) begin
                        state_s     = MEM;
                        mem_req_s   = 1'b1;
                        mem_we_s    = agu_ls;
                        mem_addr_s  = {ex_address[XLEN-1:2], 2'b00};
                        mem_wdata_s = lane_wdata_s;
                        mem_be_s    = lane_be_s;
                    end else begin
                        state_s    = DONE;
                        ex_done_s  = 1'b1;
                        misalign_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = {XLEN{1'b0}};
                    mem_wdata_s = {XLEN{1'b0}};
                    mem_be_s    = {BE_W{1'b0}};
                    if (ls_r == LS_STORE) begin
                        state_s   = DONE;
                        ex_done_s = 1'b1;
                    end else if (tag_valid_r) begin
                        state_s    = WB;
                        cdb_req_s  = 1'b1;
                        cdb_tag_s  = tag_r;
                        cdb_data_s = ld_result_s;
                    end else begin
                        state_s   = DONE;
                        ex_done_s = 1'b1;
                    end
                end else begin
                    state_s = MEM;
                end
            end
            WB: begin
                if (bus.cdb_grant) begin
                    state_s    = DONE;
                    ex_done_s  = 1'b1;
                    cdb_req_s  = 1'b0;
                    cdb_tag_s  = {TAG_W{1'b0}};
                    cdb_data_s = {XLEN{1'b0}};
                end else begin
                    state_s = WB;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, capture and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            addr_lo_r   <= 2'b00;
            funct3_r    <= 3'b000;
            ls_r        <= 1'b0;
            tag_r       <= {TAG_W{1'b0}};
            tag_valid_r <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            mem_be_r    <= {BE_W{1'b0}};
            cdb_req_r   <= 1'b0;
            cdb_tag_r   <= {TAG_W{1'b0}};
            cdb_data_r  <= {XLEN{1'b0}};
            ex_done_r   <= 1'b0;
            misalign_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_lo_r   <= addr_lo_s;
            funct3_r    <= funct3_s;
            ls_r        <= ls_s;
            tag_r       <= tag_s;
            tag_valid_r <= tag_valid_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_be_r    <= mem_be_s;
            cdb_req_r   <= cdb_req_s;
            cdb_tag_r   <= cdb_tag_s;
            cdb_data_r  <= cdb_data_s;
            ex_done_r   <= ex_done_s;
            misalign_r  <= misalign_s;
        end
    end

    assign ex_done          = ex_done_r;
    assign misalign_err     = misalign_r;
    assign bus.mem_req      = mem_req_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.mem_be       = mem_be_r;
    assign bus.cdb_req      = cdb_req_r;
    assign bus.cdb_req_tag  = cdb_tag_r;
    assign bus.cdb_req_data = cdb_data_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected behaviour, a negedge
// monitor follows the protocol and compares outputs every cycle.
module tb_lsu_ctrl;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] ex_address = 32'd0;
    logic [31:0] ex_data = 32'd0;
    logic [5:0]  rd_tag = 6'd0;
    logic        rd_tag_valid = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic        agu_ls = 1'b0;
    logic        ex_done;
    logic        misalign_err;

    always #5 clk = ~clk;

    lsu_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    lsu_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .ex_address   (ex_address),
        .ex_data      (ex_data),
        .rd_tag       (rd_tag),
        .rd_tag_valid (rd_tag_valid),
        .funct3       (funct3),
        .agu_ls       (agu_ls),
        .ex_done      (ex_done),
        .misalign_err (misalign_err),
        .bus          (bus.master)
    );

    typedef struct {
        logic        err;
        logic        store;
        logic        wb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [5:0]  tag;
        logic [31:0] ldata;
    } exp_t;

    typedef enum {P_IDLE, P_MEM, P_WB, P_DONE} ph_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour from the access rules, in plain arithmetic
    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [5:0] tag, input logic tv,
                                   input logic [2:0] f3, input logic ls,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          size;
        int          a;
        logic [31:0] v;
        a = int'(addr % 32'd4);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) e.err = 1'b1;
        else e.err = (ls && f3 > 3'd2) || ((a % size) != 0);
        e.store = ls;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.be    = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << a);
        if (!ls)            e.wdata = 32'd0;
        else if (size == 1) e.wdata = (data & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e.wdata = (data & 32'hFFFF) * 32'h0001_0001;
        else                e.wdata = data;
        v = rdata >> (8 * a);
        if (size == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        e.ldata = v;
        e.tag   = tag;
        e.wb    = !e.err && !ls && tv;
        return e;
    endfunction

    // Monitor: compares every cycle against the current expected phase
    initial begin
        ph_t  ph;
        exp_t cur;
        ph = P_IDLE;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
                chk("rst_cdb_req", {31'd0, bus.cdb_req}, 32'd0);
                chk("rst_ex_done", {31'd0, ex_done}, 32'd0);
                chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
                ph = P_IDLE;
                exp_q.delete();
            end else begin
                chk("mem_req", {31'd0, bus.mem_req}, {31'd0, ph == P_MEM});
                chk("cdb_req", {31'd0, bus.cdb_req}, {31'd0, ph == P_WB});
                chk("ex_done", {31'd0, ex_done}, {31'd0, ph == P_DONE});
                chk("misalign_err", {31'd0, misalign_err}, {31'd0, ph == P_DONE && cur.err});
                if (ph == P_MEM) begin
                    chk("mem_we", {31'd0, bus.mem_we}, {31'd0, cur.store});
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_wdata", bus.mem_wdata, cur.wdata);
                    chk("mem_be", {28'd0, bus.mem_be}, {28'd0, cur.be});
                end
                if (ph == P_WB) begin
                    chk("cdb_tag", {26'd0, bus.cdb_req_tag}, {26'd0, cur.tag});
                    chk("cdb_data", bus.cdb_req_data, cur.ldata);
                end
                case (ph)
                    P_IDLE: if (issue_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_issue", 32'd1, 32'd0);
                        end else begin
                            cur = exp_q.pop_front();
                            ph = cur.err ? P_DONE : P_MEM;
                        end
                    end
                    P_MEM: if (bus.mem_ack) ph = cur.wb ? P_WB : P_DONE;
                    P_WB:  if (bus.cdb_grant) ph = P_DONE;
                    default: ph = P_IDLE;
                endcase
            end
        end
    end

    // Issue one op and act as memory/arbiter until ex_done; leaves at +1 after the DONE edge
    task automatic run_op(input logic [31:0] addr, input logic [31:0] data,
                          input logic [5:0] tag, input logic tv,
                          input logic [2:0] f3, input logic ls,
                          input int ack_dly, input int grant_dly,
                          input logic [31:0] rdata);
        int mcnt = 0;
        int gcnt = 0;
        bit acked = 0;
        bit granted = 0;
        bit done = 0;
        exp_q.push_back(model(addr, data, tag, tv, f3, ls, rdata));
        issue_valid  = 1'b1;
        ex_address   = addr;
        ex_data      = data;
        rd_tag       = tag;
        rd_tag_valid = tv;
        funct3       = f3;
        agu_ls       = ls;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            bus.mem_ack   = 1'b0;
            bus.cdb_grant = 1'b0;
            bus.mem_rdata = $urandom;
            if (ex_done) begin
                done = 1;
            end else begin
                if (bus.mem_req && !acked) begin
                    if (mcnt == ack_dly) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rdata;
                        acked = 1;
                    end else mcnt++;
                end
                if (bus.cdb_req && !granted) begin
                    if (gcnt == grant_dly) begin
                        bus.cdb_grant = 1'b1;
                        granted = 1;
                    end else gcnt++;
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL op_timeout: got no ex_done expected ex_done within 60 cycles (addr %h)", addr);
        end
        issue_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bit seen;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        bus.cdb_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // SW, SB, LB/LBU, LB without writeback, LH with slow grant, errors
        run_op(32'h100, 32'hDEADBEEF, 6'd1, 1'b1, 3'd2, 1'b1, 1, 0, 32'h0);
        run_op(32'h101, 32'h000000AB, 6'd2, 1'b1, 3'd0, 1'b1, 0, 0, 32'h0);
        run_op(32'h203, 32'h0, 6'd5, 1'b1, 3'd0, 1'b0, 0, 0, 32'h80112233);
        run_op(32'h203, 32'h0, 6'd5, 1'b1, 3'd4, 1'b0, 0, 0, 32'h80112233);
        run_op(32'h203, 32'h0, 6'd5, 1'b0, 3'd0, 1'b0, 0, 0, 32'h80112233);
        run_op(32'h102, 32'h0, 6'd7, 1'b1, 3'd1, 1'b0, 0, 3, 32'hBEEF1234);
        run_op(32'h102, 32'h0, 6'd8, 1'b1, 3'd2, 1'b0, 0, 0, 32'h0);
        run_op(32'h100, 32'h0, 6'd9, 1'b1, 3'd3, 1'b0, 0, 0, 32'h0);
        run_op(32'h100, 32'h1234, 6'd9, 1'b1, 3'd4, 1'b1, 0, 0, 32'h0);

        // Reset in the middle of a memory request
        exp_q.push_back(model(32'h40, 32'h55AA55AA, 6'd3, 1'b1, 3'd2, 1'b1, 32'h0));
        issue_valid = 1'b1;
        ex_address  = 32'h40;
        ex_data     = 32'h55AA55AA;
        funct3      = 3'd2;
        agu_ls      = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_req) seen = 1;
        end
        chk("rst_test_mem_req_seen", {31'd0, seen}, 32'd1);
        #2;
        rst = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("async_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        bus.mem_ack = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_after_rst_ignored", {31'd0, bus.mem_req}, 32'd0);
        bus.mem_ack = 1'b0;
        run_op(32'h44, 32'hCAFEF00D, 6'd4, 1'b1, 3'd2, 1'b1, 0, 0, 32'h0);

        // Randomized ops, back to back
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(a, $urandom, 6'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
